// File: rtl/hazard_forward_unit.sv
// Load-use stall and operand-forwarding unit for an in-order pipeline.
// Keeps a tag copy of every in-flight instruction from EX onward and derives forward selects and stalls from it.
module hazard_forward_unit #(
    parameter int NSTAGE     = 2,
    parameter int LOAD_READY = 2,
    parameter int RW         = 5,
    localparam int FW        = $clog2(NSTAGE + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          advance,
    input  logic          flush,
    input  logic          issue_valid,
    input  logic [RW-1:0] rs_ID,
    input  logic [RW-1:0] rt_ID,
    input  logic          uses_rt_ID,
    input  logic [RW-1:0] wsel_ID,
    input  logic          WEN_ID,
    input  logic          dREN_ID,
    output logic [FW-1:0] forward_A,
    output logic [FW-1:0] forward_B,
    output logic          stall_ID,
    output logic          fwd_err,
    output logic [15:0]   stall_cnt
);

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic          uses_rt;
        logic [RW-1:0] wsel;
        logic          wen;
        logic          load;
    } tag_t;

    tag_t        tags_q [NSTAGE+1];
    tag_t        tags_d [NSTAGE+1];
    tag_t        id_tag;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [FW-1:0] fwd_a, fwd_b;
    logic        stall, err;

    function automatic logic hits(input tag_t t, input logic [RW-1:0] r);
        return t.valid && t.wen && (t.wsel == r) && (r != '0);
    endfunction

    // Scan oldest to youngest so the youngest matching producer is the last one written.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (tags_q[0].valid && hits(tags_q[k], tags_q[0].rs))
                fwd_a = FW'(k);
            if (tags_q[0].valid && tags_q[0].uses_rt && hits(tags_q[k], tags_q[0].rt))
                fwd_b = FW'(k);
        end
    end

    always_comb begin
        err = 1'b0;
        for (int k = 1; k <= NSTAGE; k++) begin
            if ((k < LOAD_READY) && tags_q[k].load && ((fwd_a == FW'(k)) || (fwd_b == FW'(k))))
                err = 1'b1;
        end
    end

    // A load in stage s is usable by the ID instruction one stage later, at s+1.
    always_comb begin
        stall = 1'b0;
        for (int s = 0; s <= NSTAGE; s++) begin
            if ((s + 1 < LOAD_READY) && tags_q[s].load &&
                (hits(tags_q[s], rs_ID) || (uses_rt_ID && hits(tags_q[s], rt_ID))))
                stall = 1'b1;
        end
        stall = stall && issue_valid && !flush;
    end

    always_comb begin
        id_tag = '{valid:   issue_valid && !stall && !flush,
                   rs:      rs_ID,
                   rt:      rt_ID,
                   uses_rt: uses_rt_ID,
                   wsel:    wsel_ID,
                   wen:     WEN_ID,
                   load:    dREN_ID};
        tags_d      = tags_q;
        stall_cnt_d = stall_cnt_q;
        if (advance) begin
            for (int k = NSTAGE; k >= 1; k--)
                tags_d[k] = tags_q[k-1];
            tags_d[0] = id_tag;
            if (stall && (stall_cnt_q != 16'hFFFF))
                stall_cnt_d = stall_cnt_q + 16'd1;
        end else if (flush) begin
            tags_d[0].valid = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k <= NSTAGE; k++)
                tags_q[k] <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int k = 0; k <= NSTAGE; k++)
                tags_q[k] <= tags_d[k];
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign forward_A = fwd_a;
    assign forward_B = fwd_b;
    assign stall_ID  = stall;
    assign fwd_err   = err;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: default instance checked every cycle against a reference model,
// plus a NSTAGE=4 / LOAD_READY=3 instance for the late-load-ready scenario.
module tb_hazard_forward_unit;
    localparam int NS = 2;
    localparam int LR = 2;
    localparam int W  = 22;

    typedef struct packed {
        logic       iv;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
        logic [4:0] ws;
        logic       wen;
        logic       ld;
    } id_t;

    logic CLK = 1'b0;
    logic RST = 1'b1, advance = 1'b0, flush = 1'b0, issue_valid = 1'b0;
    logic uses_rt_ID = 1'b0, WEN_ID = 1'b0, dREN_ID = 1'b0;
    logic [4:0] rs_ID = '0, rt_ID = '0, wsel_ID = '0;
    logic [1:0] forward_A, forward_B;
    logic stall_ID, fwd_err;
    logic [15:0] stall_cnt;
    logic [2:0] forward_A2, forward_B2;
    logic stall_ID2, fwd_err2;
    logic [15:0] stall_cnt2;

    int n_assert = 0;
    int n_fail   = 0;
    int n_cyc    = 0;
    logic [W-1:0] exp_q[$];

    always #5 CLK = ~CLK;

    hazard_forward_unit dut (
        .CLK(CLK), .RST(RST), .advance(advance), .flush(flush), .issue_valid(issue_valid),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID), .wsel_ID(wsel_ID),
        .WEN_ID(WEN_ID), .dREN_ID(dREN_ID), .forward_A(forward_A), .forward_B(forward_B),
        .stall_ID(stall_ID), .fwd_err(fwd_err), .stall_cnt(stall_cnt));

    hazard_forward_unit #(.NSTAGE(4), .LOAD_READY(3), .RW(5)) dut2 (
        .CLK(CLK), .RST(RST), .advance(advance), .flush(flush), .issue_valid(issue_valid),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID), .wsel_ID(wsel_ID),
        .WEN_ID(WEN_ID), .dREN_ID(dREN_ID), .forward_A(forward_A2), .forward_B(forward_B2),
        .stall_ID(stall_ID2), .fwd_err(fwd_err2), .stall_cnt(stall_cnt2));

    // Reference model of the default instance.
    bit         m_v   [0:NS];
    logic [4:0] m_rs  [0:NS];
    logic [4:0] m_rt  [0:NS];
    logic [4:0] m_ws  [0:NS];
    bit         m_urt [0:NS];
    bit         m_wen [0:NS];
    bit         m_ld  [0:NS];
    int         m_cnt = 0;

    function automatic bit m_hit(int k, logic [4:0] r);
        return m_v[k] && m_wen[k] && (m_ws[k] == r) && (r != 5'd0);
    endfunction

    function automatic int m_sel(logic [4:0] r);
        for (int k = 1; k <= NS; k++)
            if (m_hit(k, r)) return k;
        return 0;
    endfunction

    function automatic int m_fa();
        return m_v[0] ? m_sel(m_rs[0]) : 0;
    endfunction

    function automatic int m_fb();
        return (m_v[0] && m_urt[0]) ? m_sel(m_rt[0]) : 0;
    endfunction

    function automatic bit m_stall();
        if (!issue_valid || flush) return 1'b0;
        for (int s = 0; s <= NS; s++)
            if ((s + 1 < LR) && m_ld[s] && (m_hit(s, rs_ID) || (uses_rt_ID && m_hit(s, rt_ID))))
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_err();
        int a, b;
        a = m_fa();
        b = m_fb();
        return (a != 0 && a < LR && m_ld[a]) || (b != 0 && b < LR && m_ld[b]);
    endfunction

    always @(posedge CLK) begin
        bit st;
        st = m_stall();
        if (RST) begin
            for (int k = 0; k <= NS; k++) m_v[k] = 1'b0;
            m_cnt = 0;
        end else if (advance) begin
            for (int k = NS; k >= 1; k--) begin
                m_v[k] = m_v[k-1]; m_rs[k] = m_rs[k-1]; m_rt[k] = m_rt[k-1];
                m_ws[k] = m_ws[k-1]; m_urt[k] = m_urt[k-1];
                m_wen[k] = m_wen[k-1]; m_ld[k] = m_ld[k-1];
            end
            m_v[0] = issue_valid && !st && !flush;
            m_rs[0] = rs_ID; m_rt[0] = rt_ID; m_ws[0] = wsel_ID;
            m_urt[0] = uses_rt_ID; m_wen[0] = WEN_ID; m_ld[0] = dREN_ID;
            if (st && m_cnt < 65535) m_cnt++;
        end else if (flush) begin
            m_v[0] = 1'b0;
        end
    end

    function automatic id_t op_ld(logic [4:0] ws, logic [4:0] rs);
        return '{iv:1'b1, rs:rs, rt:5'd0, urt:1'b0, ws:ws, wen:1'b1, ld:1'b1};
    endfunction
    function automatic id_t op_r(logic [4:0] ws, logic [4:0] rs, logic [4:0] rt);
        return '{iv:1'b1, rs:rs, rt:rt, urt:1'b1, ws:ws, wen:1'b1, ld:1'b0};
    endfunction
    function automatic id_t op_i(logic [4:0] ws, logic [4:0] rs, logic [4:0] rt);
        return '{iv:1'b1, rs:rs, rt:rt, urt:1'b0, ws:ws, wen:1'b1, ld:1'b0};
    endfunction
    function automatic id_t op_nop();
        return '{iv:1'b0, rs:5'd0, rt:5'd0, urt:1'b0, ws:5'd0, wen:1'b0, ld:1'b0};
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the falling edge, then score the settled outputs.
    task automatic cyc(input bit rst, input bit adv, input bit fl, input id_t id);
        logic [W-1:0] exp_w, obs_w;
        @(negedge CLK);
        n_cyc++;
        RST = rst; advance = adv; flush = fl;
        issue_valid = id.iv; rs_ID = id.rs; rt_ID = id.rt; uses_rt_ID = id.urt;
        wsel_ID = id.ws; WEN_ID = id.wen; dREN_ID = id.ld;
        #1;
        exp_q.push_back({2'(m_fa()), 2'(m_fb()), m_stall(), m_err(), 16'(m_cnt)});
        obs_w = {forward_A, forward_B, stall_ID, fwd_err, stall_cnt};
        exp_w = exp_q.pop_front();
        n_assert++;
        assert (obs_w === exp_w) else begin
            n_fail++;
            $error("FAIL scoreboard cyc=%0d observed=%h expected=%h", n_cyc, obs_w, exp_w);
        end
        n_assert++;
        assert (fwd_err2 === 1'b0) else begin
            n_fail++;
            $error("FAIL fwd_err2 cyc=%0d observed=%b expected=0", n_cyc, fwd_err2);
        end
    endtask

    initial begin
        // Reset
        cyc(1, 1, 0, op_ld(5'd3, 5'd1));
        cyc(0, 1, 0, op_nop());
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_fa", forward_A, 0);
        chk("rst_stall", stall_ID, 0);
        chk("rst_cnt2", stall_cnt2, 0);

        // Load-use: one stall, then WB forward
        cyc(0, 1, 0, op_ld(5'd3, 5'd1));
        cyc(0, 1, 0, op_r(5'd4, 5'd3, 5'd5));
        chk("lu_stall", stall_ID, 1);
        cyc(0, 1, 0, op_r(5'd4, 5'd3, 5'd5));
        chk("lu_release", stall_ID, 0);
        chk("lu_cnt", stall_cnt, 1);
        cyc(0, 1, 0, op_nop());
        chk("lu_fa", forward_A, 2);
        chk("lu_err", fwd_err, 0);

        // Back-to-back ALU dependence
        cyc(0, 1, 0, op_r(5'd3, 5'd1, 5'd2));
        cyc(0, 1, 0, op_r(5'd6, 5'd3, 5'd3));
        cyc(0, 1, 0, op_r(5'd7, 5'd3, 5'd0));
        chk("b2b_fa", forward_A, 1);
        chk("b2b_fb", forward_B, 1);
        chk("b2b_stall", stall_ID, 0);
        cyc(0, 1, 0, op_nop());
        chk("third_fa", forward_A, 2);
        chk("third_fb_r0", forward_B, 0);

        // Immediate rt field and register zero
        cyc(0, 1, 0, op_r(5'd7, 5'd1, 5'd2));
        cyc(0, 1, 0, op_i(5'd2, 5'd1, 5'd7));
        cyc(0, 1, 0, op_nop());
        chk("imm_fb", forward_B, 0);
        cyc(0, 1, 0, op_r(5'd0, 5'd1, 5'd2));
        cyc(0, 1, 0, op_r(5'd5, 5'd0, 5'd0));
        cyc(0, 1, 0, op_ld(5'd0, 5'd1));
        chk("r0_fa", forward_A, 0);
        chk("r0_fb", forward_B, 0);
        cyc(0, 1, 0, op_r(5'd5, 5'd0, 5'd0));
        chk("r0_stall", stall_ID, 0);

        // Stall held while advance is low
        cyc(0, 1, 0, op_ld(5'd3, 5'd1));
        repeat (3) begin
            cyc(0, 0, 0, op_r(5'd4, 5'd3, 5'd5));
            chk("hold_stall", stall_ID, 1);
            chk("hold_cnt", stall_cnt, 1);
        end
        cyc(0, 1, 0, op_r(5'd4, 5'd3, 5'd5));
        chk("hold_adv_stall", stall_ID, 1);
        cyc(0, 1, 0, op_r(5'd4, 5'd3, 5'd5));
        chk("hold_after_cnt", stall_cnt, 2);
        cyc(0, 1, 0, op_nop());
        chk("hold_fa", forward_A, 2);

        // Flush coinciding with a would-be stall
        cyc(0, 1, 0, op_ld(5'd3, 5'd1));
        cyc(0, 1, 1, op_r(5'd4, 5'd3, 5'd5));
        chk("flush_stall", stall_ID, 0);
        cyc(0, 1, 0, op_nop());
        chk("flush_cnt", stall_cnt, 2);
        chk("flush_fa", forward_A, 0);

        // Reset in the middle of a stall
        cyc(0, 1, 0, op_ld(5'd9, 5'd1));
        cyc(0, 1, 0, op_r(5'd4, 5'd9, 5'd0));
        chk("rs_stall_pre", stall_ID, 1);
        cyc(1, 1, 0, op_r(5'd4, 5'd9, 5'd0));
        cyc(0, 1, 0, op_r(5'd4, 5'd9, 5'd0));
        chk("rs_stall_post", stall_ID, 0);
        chk("rs_cnt_post", stall_cnt, 0);

        // Deep pipeline: load usable only from stage 3
        cyc(0, 1, 0, op_ld(5'd8, 5'd1));
        cyc(0, 1, 0, op_r(5'd4, 5'd8, 5'd0));
        chk("deep_stall1", stall_ID2, 1);
        cyc(0, 1, 0, op_r(5'd4, 5'd8, 5'd0));
        chk("deep_stall2", stall_ID2, 1);
        cyc(0, 1, 0, op_r(5'd4, 5'd8, 5'd0));
        chk("deep_release", stall_ID2, 0);
        cyc(0, 1, 0, op_nop());
        chk("deep_fa", forward_A2, 3);
        chk("deep_err", fwd_err2, 0);
        chk("deep_cnt", stall_cnt2, 2);

        // Random stream against the model
        for (int i = 0; i < 400; i++) begin
            id_t t;
            t.iv  = ($urandom_range(0, 3) != 0);
            t.rs  = 5'($urandom_range(0, 7));
            t.rt  = 5'($urandom_range(0, 7));
            t.urt = 1'($urandom_range(0, 1));
            t.ws  = 5'($urandom_range(0, 7));
            t.wen = ($urandom_range(0, 4) != 0);
            t.ld  = ($urandom_range(0, 2) == 0);
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 9) == 0), t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
